// File: rtl/phy_tx_lane_sched.sv
// Two-lane transmit scheduler. Buffers 32-bit words in a small FIFO, runs
// the COM training sequence after reset or retrain, then hands out up to two
// words per 4-cycle frame so both lanes always start a word together.
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | sending COM frames; init_cnt counts frames already loaded
// RUN   | link trained; each frame start pops up to two words
module phy_tx_lane_sched #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned INIT_FRAMES = 4,
  parameter logic [7:0]  COM         = 8'hBC,
  parameter logic [7:0]  IDL         = 8'h7C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  input  logic        retrain,
  output logic        ready,
  output logic [7:0]  lane0_out,
  output logic [7:0]  lane1_out,
  output logic        lane0_valid,
  output logic        lane1_valid,
  output logic        active
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = $clog2(INIT_FRAMES + 1);

  localparam logic [IW-1:0] INIT_DONE = IW'(INIT_FRAMES);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [31:0]   COM_WORD  = {4{COM}};
  localparam logic [31:0]   IDL_WORD  = {4{IDL}};

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Frame timing and FSM registers
  logic [1:0]    bc_q;
  state_e        state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic          pend_q, pend_d;

  // Lane shift registers: the byte on the wire is always the top byte
  logic [31:0]   sh0_q, sh0_d;
  logic [31:0]   sh1_q, sh1_d;
  logic          v0_q, v0_d;
  logic          v1_q, v1_d;

  // Word FIFO
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count_q, count_d;

  logic          frame_start;
  logic          push;
  logic          load_run;
  logic [1:0]    n_pop;

  assign frame_start = (bc_q == 2'd3);
  assign active      = (state_q == ST_RUN);
  assign ready       = active && !pend_q && (count_q < FULL_CNT);
  assign push        = valid_in && ready;
  assign rd_ptr_nxt  = rd_ptr_q + AW'(1);

  assign lane0_out   = sh0_q[31:24];
  assign lane1_out   = sh1_q[31:24];
  assign lane0_valid = v0_q;
  assign lane1_valid = v1_q;

  // Next-state: FSM transitions, frame loading, FIFO pointer arithmetic.
  // INIT leaves on the frame start after its last COM frame; that same
  // edge loads the first RUN frame, so active/ready rise exactly as the
  // last COM byte finishes.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    pend_d     = pend_q;
    sh0_d      = {sh0_q[23:0], 8'h00};
    sh1_d      = {sh1_q[23:0], 8'h00};
    v0_d       = v0_q;
    v1_d       = v1_q;
    load_run   = 1'b0;
    n_pop      = 2'd0;

    if (state_q == ST_RUN && retrain) begin
      pend_d = 1'b1;
    end

    if (frame_start) begin
      if (state_q == ST_INIT) begin
        if (init_cnt_q == INIT_DONE) begin
          init_cnt_d = '0;
          state_d    = ST_RUN;
          load_run   = 1'b1;
        end else begin
          sh0_d      = COM_WORD;
          sh1_d      = COM_WORD;
          v0_d       = 1'b0;
          v1_d       = 1'b0;
          init_cnt_d = init_cnt_q + IW'(1);
        end
      end else begin
        if (pend_q) begin
          // This COM frame is the first of the retrain sequence.
          pend_d     = 1'b0;
          sh0_d      = COM_WORD;
          sh1_d      = COM_WORD;
          v0_d       = 1'b0;
          v1_d       = 1'b0;
          init_cnt_d = IW'(1);
          state_d    = ST_INIT;
        end else begin
          load_run = 1'b1;
        end
      end
    end

    if (load_run) begin
      // Occupancy before the edge; a word pushed now waits for the next frame.
      if (count_q >= CW'(2)) begin
        n_pop = 2'd2;
      end else begin
        n_pop = count_q[1:0];
      end
      case (n_pop)
        2'd2: begin
          sh0_d = mem_q[rd_ptr_q];
          sh1_d = mem_q[rd_ptr_nxt];
          v0_d  = 1'b1;
          v1_d  = 1'b1;
        end
        2'd1: begin
          sh0_d = mem_q[rd_ptr_q];
          sh1_d = IDL_WORD;
          v0_d  = 1'b1;
          v1_d  = 1'b0;
        end
        default: begin
          sh0_d = IDL_WORD;
          sh1_d = IDL_WORD;
          v0_d  = 1'b0;
          v1_d  = 1'b0;
        end
      endcase
    end

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(n_pop);
    count_d  = count_q + CW'(push) - CW'(n_pop);
  end

  // Control, lane and FIFO-pointer registers; reset forces outputs to 00/0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bc_q       <= 2'd3;
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      pend_q     <= 1'b0;
      sh0_q      <= '0;
      sh1_q      <= '0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      bc_q       <= bc_q + 2'd1;
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      pend_q     <= pend_d;
      sh0_q      <= sh0_d;
      sh1_q      <= sh1_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents are meaningless once count is reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_phy_tx_lane_sched.sv
// Directed bench for phy_tx_lane_sched: stimulus pushes hand-computed frames
// into a queue, a frame monitor compares every data frame it sees.
module tb_phy_tx_lane_sched;

  localparam logic [7:0]  COM   = 8'hBC;
  localparam logic [7:0]  IDL   = 8'h7C;
  localparam logic [31:0] IDL_W = 32'h7C7C7C7C;
  localparam logic [31:0] COM_W = 32'hBCBCBCBC;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        valid_in;
  logic        retrain;
  logic        ready;
  logic [7:0]  lane0_out;
  logic [7:0]  lane1_out;
  logic        lane0_valid;
  logic        lane1_valid;
  logic        active;

  typedef struct packed {
    logic [31:0] w0;
    logic [31:0] w1;
    logic        v0;
    logic        v1;
  } frame_t;

  frame_t exp_q[$];

  int n_vec  = 0;
  int n_miss = 0;
  int data_frames = 0;
  int com_frames  = 0;

  logic [1:0] tb_bc;

  // monitor state
  logic [31:0] m_l0w, m_l1w;
  logic        m_v0, m_v1, m_vbad;
  logic        m_started;
  frame_t      m_act, m_exp;

  phy_tx_lane_sched #(
    .DEPTH(4), .INIT_FRAMES(4), .COM(8'hBC), .IDL(8'h7C)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .retrain(retrain), .ready(ready), .lane0_out(lane0_out),
    .lane1_out(lane1_out), .lane0_valid(lane0_valid),
    .lane1_valid(lane1_valid), .active(active)
  );

  always #5 clk = ~clk;

  // Bench-side frame position: value of bc during the current cycle
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_bc <= 2'd3;
    else        tb_bc <= tb_bc + 2'd1;
  end

  function automatic void chk(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Frame monitor: assembles 4 bytes per lane and checks each finished frame
  initial begin : monitor
    m_started = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        m_started = 1'b0;
      end else if (m_started || tb_bc == 2'd0) begin
        m_started = 1'b1;
        if (tb_bc == 2'd0) begin
          m_l0w  = '0;
          m_l1w  = '0;
          m_v0   = lane0_valid;
          m_v1   = lane1_valid;
          m_vbad = 1'b0;
        end else if (lane0_valid !== m_v0 || lane1_valid !== m_v1) begin
          m_vbad = 1'b1;
        end
        m_l0w = {m_l0w[23:0], lane0_out};
        m_l1w = {m_l1w[23:0], lane1_out};
        if (tb_bc == 2'd3) begin
          chk("valid_hold", 128'(m_vbad), 128'(0));
          m_act = '{w0: m_l0w, w1: m_l1w, v0: m_v0, v1: m_v1};
          if (m_v0 || m_v1) begin
            data_frames++;
            if (exp_q.size() == 0) begin
              n_vec++;
              n_miss++;
              $display("FAIL unexpected_data: got %h, expected no data frame", m_act);
            end else begin
              m_exp = exp_q.pop_front();
              chk("data_frame", 128'(m_act), 128'(m_exp));
            end
          end else begin
            if (m_l0w == COM_W && m_l1w == COM_W) com_frames++;
            chk("idle_symbols",
                128'((m_l0w == COM_W && m_l1w == COM_W) || (m_l0w == IDL_W && m_l1w == IDL_W)),
                128'(1));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic wait_bc(input logic [1:0] k);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (tb_bc != k && g < 8);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [31:0] w, output int stalls);
    stalls   = 0;
    data_in  = w;
    valid_in = 1'b1;
    while (!ready && stalls < 64) begin
      @(negedge clk);
      stalls++;
    end
    if (!ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL send_timeout: ready=%0b, expected 1 for word %h", ready, w);
    end
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic wait_drained();
    int g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("drain", 128'(exp_q.size()), 128'(0));
  endtask

  // Called at the release negedge: 16 COM cycles, then the first RUN frame
  task automatic check_training();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("training_com",
          {lane0_out, lane1_out, lane0_valid, lane1_valid, active, ready},
          {COM, COM, 4'b0000});
    end
    @(negedge clk);
    chk("run_entry",
        {lane0_out, lane1_out, lane0_valid, lane1_valid, active, ready},
        {IDL, IDL, 4'b0011});
  endtask

  initial begin : stimulus
    int st;
    int total_stall;
    int cnt;
    int g;
    int com_before;
    int data_before;
    logic [31:0] w, wprev;

    reset    = 1'b1;
    valid_in = 1'b0;
    retrain  = 1'b0;
    data_in  = '0;
    #2 reset = 1'b0;
    #1;
    chk("reset_values",
        {lane0_out, lane1_out, lane0_valid, lane1_valid, ready, active}, 128'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_training();

    // two words -> one full frame
    wait_bc(2'd0);
    send(32'h11223344, st);
    send(32'h55667788, st);
    exp_q.push_back('{w0: 32'h11223344, w1: 32'h55667788, v0: 1'b1, v1: 1'b1});
    wait_drained();

    // single word -> lane1 idles
    wait_bc(2'd0);
    send(32'hDEADBEEF, st);
    exp_q.push_back('{w0: 32'hDEADBEEF, w1: IDL_W, v0: 1'b1, v1: 1'b0});
    wait_drained();

    // sustained stream: 12 words, ready stalls 2 cycles in frames 2..4
    wait_bc(2'd0);
    total_stall = 0;
    wprev = '0;
    for (int i = 0; i < 12; i++) begin
      w = 32'hC0DE0000 + 32'(i);
      send(w, st);
      total_stall += st;
      if (i % 2 == 1) exp_q.push_back('{w0: wprev, w1: w, v0: 1'b1, v1: 1'b1});
      wprev = w;
    end
    chk("stream_stalls", 128'(total_stall), 128'(6));
    wait_drained();

    // retrain with three words buffered
    com_before = com_frames;
    wait_bc(2'd3);
    send(32'hA0A0A0A0, st);
    send(32'hA1A1A1A1, st);
    retrain = 1'b1;
    send(32'hA2A2A2A2, st);
    retrain = 1'b0;
    exp_q.push_back('{w0: 32'hA0A0A0A0, w1: 32'hA1A1A1A1, v0: 1'b1, v1: 1'b1});
    exp_q.push_back('{w0: 32'hA2A2A2A2, w1: IDL_W, v0: 1'b1, v1: 1'b0});
    chk("retrain_pending", {active, ready}, 2'b10);
    g = 0;
    while (active && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("retrain_drop", 128'(active), 128'(0));
    cnt = 0;
    while (!active && cnt < 40) begin
      chk("retrain_ready_low", 128'(ready), 128'(0));
      @(negedge clk);
      cnt++;
    end
    chk("retrain_com_cycles", 128'(cnt), 128'(16));
    wait_drained();
    chk("retrain_com_frames", 128'(com_frames - com_before), 128'(4));

    // reset asserted mid data frame at bc==2
    wait_bc(2'd0);
    send(32'hF1F2F3F4, st);
    send(32'hE1E2E3E4, st);
    send(32'hD1D2D3D4, st);
    wait_bc(2'd2);
    chk("mid_frame_byte", {lane0_out, lane0_valid}, {8'hF3, 1'b1});
    #1 reset = 1'b0;
    #1;
    chk("async_reset_outputs",
        {lane0_out, lane1_out, lane0_valid, lane1_valid, ready, active}, 128'(0));
    @(negedge clk);
    @(negedge clk);
    data_before = data_frames;
    reset = 1'b1;
    check_training();
    for (int c = 0; c < 12; c++) @(negedge clk);
    chk("no_stale_words", 128'(data_frames - data_before), 128'(0));
    chk("queue_empty_end", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
